freq_gate_ctrl: RTL

FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/freq_gate_ctrl_if.sv | 24 ++
 rtl/gate_timer.sv | 32 +++
 rtl/freq_gate_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared state encoding, default phase lengths and timer load helper for the gate controller.
// Pure declarations; no timing or flow control of its own.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } fsm_state_e;

  localparam int unsigned DEF_GATE_CYCLES   = 32'd50_000_000;
  localparam int unsigned DEF_CLEAR_CYCLES  = 32'd2;
  localparam int unsigned DEF_SETTLE_CYCLES = 32'd4;

  // A phase of n cycles loads n-1 so the zero flag marks its last cycle.
  function automatic logic [31:0] phase_load(input int unsigned n);
    return 32'(n - 32'd1);
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Control/counter bundle between the gate controller (master) and its host and signal counter (slave).
// Level and pulse signals only; no handshake, no backpressure.
interface freq_gate_ctrl_if;

  logic        START;
  logic        CONT;
  logic [31:0] CNT_VAL;
  logic        CNT_EN;
  logic        CNT_nCLR;
  logic [31:0] RESULT;
  logic        VALID;
  logic        BUSY;

  modport master (
    input  START, CONT, CNT_VAL,
    output CNT_EN, CNT_nCLR, RESULT, VALID, BUSY
  );

  modport slave (
    output START, CONT, CNT_VAL,
    input  CNT_EN, CNT_nCLR, RESULT, VALID, BUSY
  );

endinterface

// File: rtl/gate_timer.sv
// 32-bit phase timer: load on phase entry, count down to zero and hold there; zero_o flags the last phase cycle.
// Load takes effect next cycle; no backpressure.
module gate_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic        zero_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency-meter sequencer: clear counter, open gate for GATE_CYCLES, settle, latch count into RESULT.
// VALID one cycle after LATCH; START ignored while busy, CONT sampled only in LATCH.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic              CLK,
  input logic              CLR,
  freq_gate_ctrl_if.master gif
);

  fsm_state_e  state_q, state_d;
  logic        timer_load;
  logic [31:0] timer_load_val;
  logic        timer_zero;
  logic        cnt_en_q, cnt_en_d;
  logic        cnt_nclr_q, cnt_nclr_d;
  logic        valid_q;
  logic [31:0] result_q;

  gate_timer u_timer (
    .clk_i      (CLK),
    .rst_i      (CLR),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gif.START) state_d = ST_CLEAR;
      ST_CLEAR:  if (timer_zero) state_d = ST_GATE;
      ST_GATE:   if (timer_zero) state_d = ST_SETTLE;
      ST_SETTLE: if (timer_zero) state_d = ST_LATCH;
      ST_LATCH:  state_d = gif.CONT ? ST_CLEAR : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Timer reloads on every phase change, including LATCH -> CLEAR in continuous mode.
  always_comb begin
    timer_load     = (state_d != state_q);
    timer_load_val = '0;
    case (state_d)
      ST_CLEAR:  timer_load_val = phase_load(CLEAR_CYCLES);
      ST_GATE:   timer_load_val = phase_load(GATE_CYCLES);
      ST_SETTLE: timer_load_val = phase_load(SETTLE_CYCLES);
      default:   timer_load_val = '0;
    endcase
  end

  // Counter controls are decoded from the next state so the flops line up with state_q.
  always_comb begin
    cnt_en_d   = (state_d == ST_GATE);
    cnt_nclr_d = (state_d != ST_CLEAR);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      cnt_en_q   <= 1'b0;
      cnt_nclr_q <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= cnt_en_d;
      cnt_nclr_q <= cnt_nclr_d;
      valid_q    <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) begin
        result_q <= gif.CNT_VAL;
      end
    end
  end

  assign gif.CNT_EN   = cnt_en_q;
  assign gif.CNT_nCLR = cnt_nclr_q;
  assign gif.RESULT   = result_q;
  assign gif.VALID    = valid_q;
  assign gif.BUSY     = (state_q != ST_IDLE);

endmodule
